// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates.
// A new divisor is applied only at a period boundary. clk_out is a registered
// waveform, not a clock. Downstream logic should use rise_tick/fall_tick as
// enables.
module clk_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [WIDTH-1:0] cnt,
  output logic             cfg_pend,
  output logic             cfg_err
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_act_q, n_act_d;
  logic [WIDTH-1:0] n_pend_q, n_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] half_c;
  logic [WIDTH-1:0] cnt_inc_c;
  logic [WIDTH-1:0] load_val_c;
  logic             wrap_c;
  logic             too_small_c;

  // Decode the period boundary and the clamped load value.
  always_comb begin
    half_c      = n_act_q >> 1;
    cnt_inc_c   = cnt_q + ONE;
    wrap_c      = en && (cnt_q == (n_act_q - ONE));
    too_small_c = (div_val < DIV_MIN);
    load_val_c  = too_small_c ? DIV_MIN : div_val;
  end

  // Next-state: advance the phase, shape the waveform, manage divisor handoff.
  always_comb begin
    cnt_d      = cnt_q;
    n_act_d    = n_act_q;
    n_pend_d   = n_pend_q;
    clk_out_d  = clk_out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    cfg_pend_d = cfg_pend_q;
    cfg_err_d  = 1'b0;

    if (en) begin
      if (wrap_c) begin
        cnt_d     = '0;
        clk_out_d = 1'b1;
        rise_d    = 1'b1;
        if (cfg_pend_q) begin
          n_act_d    = n_pend_q;
          cfg_pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_inc_c;
        if (cnt_inc_c == half_c) begin
          clk_out_d = 1'b0;
          fall_d    = 1'b1;
        end
      end
    end

    // A load on the wrap cycle applies directly to the period that starts now.
    if (div_load) begin
      cfg_err_d = too_small_c;
      n_pend_d  = load_val_c;
      if (wrap_c) begin
        n_act_d    = load_val_c;
        cfg_pend_d = 1'b0;
      end else begin
        cfg_pend_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= DIV_RST - ONE;
      n_act_q    <= DIV_RST;
      n_pend_q   <= DIV_RST;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cfg_pend_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_act_q    <= n_act_d;
      n_pend_q   <= n_pend_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign cnt       = cnt_q;
  assign cfg_pend  = cfg_pend_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed and random test of clk_div_prog against a scoreboard of predicted
// outputs.
module tb_clk_div_prog;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEF   = 4;
  localparam int unsigned VW    = WIDTH + 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] div_val = '0;
  logic             div_load = 1'b0;
  logic             clk_out, rise_tick, fall_tick, cfg_pend, cfg_err;
  logic [WIDTH-1:0] cnt;

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .cnt      (cnt),
    .cfg_pend (cfg_pend),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference state: phase, active and pending divisors.
  // The waveform is derived from the phase, not tracked as its own register.
  int unsigned m_cnt   = DEF - 1;
  int unsigned m_nact  = DEF;
  int unsigned m_npend = DEF;
  bit          m_pend  = 1'b0;
  bit          m_clk   = 1'b0;

  logic [VW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_bad = 0;

  // Predict outputs after the coming posedge and queue them.
  task automatic predict(input bit r, input bit e, input int unsigned dv, input bit ld);
    bit          err, rise, fall, wrap, nclk;
    int unsigned v;
    if (r) begin
      m_cnt = DEF - 1; m_nact = DEF; m_npend = DEF; m_pend = 0;
      err = 0; rise = 0; fall = 0; nclk = 0;
    end else begin
      v    = (dv < 2) ? 2 : dv;
      err  = ld && (dv < 2);
      wrap = e && (m_cnt == m_nact - 1);
      if (e) begin
        m_cnt = wrap ? 0 : m_cnt + 1;
        if (wrap && m_pend) begin m_nact = m_npend; m_pend = 0; end
      end
      if (ld) begin
        m_npend = v;
        if (wrap) begin m_nact = v; m_pend = 0; end
        else m_pend = 1;
      end
      nclk = (m_cnt < (m_nact >> 1));
      rise = !m_clk && nclk;
      fall = m_clk && !nclk;
    end
    m_clk = nclk;
    exp_q.push_back({nclk, rise, fall, m_pend, err, WIDTH'(m_cnt)});
  endtask

  // Apply one cycle of stimulus, then compare after the edge.
  task automatic step(input string tag, input bit r, input bit e,
                      input int unsigned dv, input bit ld);
    logic [VW-1:0] exp_v, obs_v;
    rst = r; en = e; div_val = WIDTH'(dv); div_load = ld;
    predict(r, e, dv, ld);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {clk_out, rise_tick, fall_tick, cfg_pend, cfg_err, cnt};
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_bad++;
      $error("FAIL %s: {clk,rise,fall,pend,err,cnt} observed=%b_%0d required=%b_%0d",
             tag, obs_v[VW-1:WIDTH], obs_v[WIDTH-1:0], exp_v[VW-1:WIDTH], exp_v[WIDTH-1:0]);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 0, 1'b0);
  endtask

  initial begin
    #1;
    // Reset state and the default divide-by-4 waveform
    step("reset", 1, 1, 0, 0);
    step("reset", 1, 0, 0, 0);
    assert (cnt === WIDTH'(DEF - 1) && clk_out === 1'b0) else begin
      n_bad++;
      $error("FAIL reset_const: cnt=%0d clk_out=%b required cnt=%0d clk_out=0", cnt, clk_out, DEF - 1);
    end
    n_vec++;
    run("div4", 12);

    // A load on the first edge after reset applies immediately as divide-by-5
    step("rst5", 1, 1, 0, 0);
    step("load5_wrap", 0, 1, 5, 1);
    run("div5", 15);

    // Load 6 mid-period at cnt=1
    step("rst6", 1, 1, 0, 0);
    run("pre6", 2);
    step("load6_mid", 0, 1, 6, 1);
    run("div6", 14);

    // Loads below 2 clamp to 2 and pulse cfg_err
    step("load1", 0, 1, 1, 1);
    run("div2a", 8);
    step("load9", 0, 1, 9, 1);
    run("div9", 10);
    step("load0", 0, 1, 0, 1);
    run("div2b", 12);

    // Enable gap at cnt=2 while dividing by 4
    step("rst_en", 1, 1, 0, 0);
    run("pre_gap", 3);
    for (int i = 0; i < 3; i++) step("en_off", 0, 0, 0, 0);
    run("resume", 6);

    // Load during en=0 is held pending
    step("load_off", 0, 0, 3, 1);
    step("en_off2", 0, 0, 0, 0);
    run("div3", 10);

    // Reset mid-period while clk_out=1 and a load is pending
    step("rst_mid", 1, 1, 0, 0);
    step("hi", 0, 1, 0, 0);
    step("pend_hi", 0, 1, 6, 1);
    step("rst_drop", 1, 1, 0, 0);
    run("post_rst", 9);

    // A load on a wrap uses the new divisor at once; cfg_pend stays low
    step("rst7", 1, 1, 0, 0);
    step("load7_wrap", 0, 1, 7, 1);
    run("div7", 15);

    // A second load before the boundary replaces the first
    step("lastA", 0, 1, 3, 1);
    step("lastB", 0, 1, 5, 1);
    run("last_wins", 16);

    // Random mix of enables, loads and occasional reset
    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 12), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
